// File: rtl/router_src_arbiter.sv
// Round-robin packet arbiter feeding the router's single input port.
// Grants whole packets (header, payload, parity) to one source, stalls on
// router busy, inserts an idle gap after parity, and optionally swallows
// packets addressed to port 3.
module router_src_arbiter #(
  parameter int N_SRC      = 3,
  parameter int GAP_CYCLES = 3,
  parameter bit DROP_ADDR3 = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]   src_ready,
  input  logic               busy,
  output logic               pkt_valid,
  output logic [7:0]         data_in,
  output logic [N_SRC-1:0]   grant,
  output logic               drop_pulse,
  output logic               underrun_err
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PLD,
    S_PAR,
    S_GAP,
    S_DROP
  } state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  ptr, owner, pick, next_ptr;
  logic           pick_found;
  int unsigned    idx;
  logic [5:0]     len_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [7:0]     cur_byte;
  logic           cur_valid;
  logic           in_pkt, can_take, xfer, hdr_drop;

  // Round-robin search: first requesting source at or above ptr, with wrap
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!pick_found && src_valid[idx[PW-1:0]]) begin
        pick       = idx[PW-1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Byte and valid of the currently granted source (grant is one-hot)
  always_comb begin
    cur_byte  = '0;
    cur_valid = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        cur_byte  = src_data[8*i +: 8];
        cur_valid = src_valid[i];
      end
    end
  end

  // Forwarding states honour busy; DROP consumes regardless of the router
  assign in_pkt    = (state == S_HDR) || (state == S_PLD) || (state == S_PAR);
  assign can_take  = (in_pkt & ~busy) | (state == S_DROP);
  assign src_ready = can_take ? grant : '0;
  assign xfer      = can_take & cur_valid;
  assign hdr_drop  = DROP_ADDR3 && (cur_byte[1:0] == 2'b11);
  assign next_ptr  = (owner == PW'(N_SRC - 1)) ? '0 : owner + 1'b1;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pick_found) state_nxt = S_HDR;
      S_HDR: begin
        if (xfer) begin
          if (hdr_drop)                 state_nxt = S_DROP;
          else if (cur_byte[7:2] == '0) state_nxt = S_PAR;
          else                          state_nxt = S_PLD;
        end
      end
      S_PLD:  if (xfer && len_cnt == 6'd1) state_nxt = S_PAR;
      S_PAR:  if (xfer) state_nxt = S_GAP;
      S_GAP:  if (gap_cnt == '0 && !busy) state_nxt = S_IDLE;
      S_DROP: if (xfer && len_cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: router outputs, grant, pointer, counters and status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_valid    <= 1'b0;
      data_in      <= '0;
      grant        <= '0;
      owner        <= '0;
      ptr          <= '0;
      len_cnt      <= '0;
      gap_cnt      <= '0;
      drop_pulse   <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (in_pkt && !busy && !cur_valid) underrun_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant <= {{(N_SRC-1){1'b0}}, 1'b1} << pick;
            owner <= pick;
          end
        end
        S_HDR: begin
          if (xfer) begin
            len_cnt <= cur_byte[7:2];
            if (!hdr_drop) begin
              data_in   <= cur_byte;
              pkt_valid <= 1'b1;
            end
          end
        end
        S_PLD: begin
          if (xfer) begin
            data_in   <= cur_byte;
            pkt_valid <= 1'b1;
            len_cnt   <= len_cnt - 6'd1;
          end
        end
        S_PAR: begin
          if (xfer) begin
            data_in   <= cur_byte;
            pkt_valid <= 1'b0;
            gap_cnt   <= GW'(GAP_CYCLES);
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (!busy) begin
            grant <= '0;
            ptr   <= next_ptr;
          end
        end
        S_DROP: begin
          // Payload bytes count down to zero; the byte seen at zero is parity
          if (xfer) begin
            if (len_cnt != '0) begin
              len_cnt <= len_cnt - 6'd1;
            end else begin
              drop_pulse <= 1'b1;
              grant      <= '0;
              ptr        <= next_ptr;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_src_arbiter.sv
// Scoreboard bench for router_src_arbiter: stimulus pushes expected router
// output records; a negedge monitor pops one per accepted byte and one per
// grant release (checking cycles since the last accepted byte).
module tb_router_src_arbiter;

  localparam int GAP = 3;
  // Parity accept -> GAP cycles of countdown -> one cycle at zero -> grant clears
  localparam int REL = GAP + 2;

  logic        clock;
  logic        reset;
  logic [2:0]  src_valid;
  logic [23:0] src_data;
  logic [2:0]  src_ready;
  logic        busy;
  logic        pkt_valid;
  logic [7:0]  data_in;
  logic [2:0]  grant;
  logic        drop_pulse;
  logic        underrun_err;

  typedef struct packed {
    logic        rel;
    logic [12:0] val;
  } rec_t;

  rec_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   drop_seen  = 0;

  router_src_arbiter #(
    .N_SRC(3),
    .GAP_CYCLES(GAP),
    .DROP_ADDR3(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .busy(busy),
    .pkt_valid(pkt_valid),
    .data_in(data_in),
    .grant(grant),
    .drop_pulse(drop_pulse),
    .underrun_err(underrun_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t xr(input logic pv, input logic [7:0] d, input logic [2:0] g, input logic dp);
    return {1'b0, pv, d, g, dp};
  endfunction

  function automatic rec_t rl(input int dl);
    return {1'b1, 13'(dl)};
  endfunction

  // Expected records for a forwarded packet; bytes listed LSB-first (header in [7:0])
  task automatic exp_pkt(input logic [2:0] g, input logic [63:0] b, input int n);
    for (int k = 0; k < n; k++) sb.push_back(xr(k != n - 1, b[8*k +: 8], g, 1'b0));
    sb.push_back(rl(REL));
  endtask

  task automatic hold_byte(input int s, input logic [7:0] v);
    int   t;
    logic ok;
    src_valid[s]        = 1'b1;
    src_data[8*s +: 8]  = v;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 300) begin
      @(negedge clock);
      ok = src_ready[s];
      t++;
      @(posedge clock);
      #1;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL accept_src%0d: byte %02h not taken within 300 cycles, expected src_ready", s, v);
    end
  endtask

  task automatic send(input int s, input logic [63:0] b, input int n);
    for (int k = 0; k < n; k++) hold_byte(s, b[8*k +: 8]);
    src_valid[s] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Header, a missing payload byte with busy low, then the rest of the packet
  task automatic underrun_pkt(input int s, input logic [2:0] g);
    exp_pkt(g, 64'h14_11_05, 3);
    check("underrun_clear", underrun_err, 0);
    send(s, 64'h05, 1);
    idle(2);
    check("underrun_set", underrun_err, 1);
    send(s, 64'h14_11, 2);
    idle(10);
    check("underrun_sticky", underrun_err, 1);
  endtask

  // Monitor: compare each accepted byte's output one cycle later, and grant releases
  initial begin : monitor
    logic [2:0] prev_grant;
    logic       pending;
    int         cyc;
    int         last_hs;
    rec_t       act;
    rec_t       e;
    prev_grant = '0;
    pending    = 1'b0;
    cyc        = 0;
    last_hs    = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        pending    = 1'b0;
        prev_grant = '0;
      end else begin
        if (drop_pulse) drop_seen++;
        if (pending) begin
          pending = 1'b0;
          act = {1'b0, pkt_valid, data_in, grant, drop_pulse};
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL byte_out: got %0h, expected nothing queued", act);
          end else begin
            e = sb.pop_front();
            check("byte_out", 32'(act), 32'(e));
          end
        end
        if (prev_grant != '0 && grant == '0) begin
          act = rl(cyc - last_hs);
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL release: got %0h, expected nothing queued", act);
          end else begin
            e = sb.pop_front();
            check("release", 32'(act), 32'(e));
          end
        end
        if (|(src_valid & src_ready)) begin
          pending = 1'b1;
          last_hs = cyc;
        end
        prev_grant = grant;
      end
    end
  end

  initial begin : watchdog
    #400000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset     = 1'b1;
    busy      = 1'b0;
    src_valid = '0;
    src_data  = '0;
    idle(2);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_data_in", data_in, 0);
    check("rst_grant", grant, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_drop_pulse", drop_pulse, 0);
    check("rst_underrun", underrun_err, 0);
    reset = 1'b0;

    // Contention from reset: order 0,1,2
    exp_pkt(3'b001, 64'h14_11_05, 3);
    exp_pkt(3'b010, 64'h24_22_06, 3);
    exp_pkt(3'b100, 64'h37_33_04, 3);
    fork
      send(0, 64'h14_11_05, 3);
      send(1, 64'h24_22_06, 3);
      send(2, 64'h37_33_04, 3);
    join
    idle(10);

    // Burst from src1 and src2: src1 first; src2 carries a zero-length packet
    exp_pkt(3'b010, 64'h77_66_55_0A, 4);
    exp_pkt(3'b100, 64'h01_01, 2);
    fork
      send(1, 64'h77_66_55_0A, 4);
      send(2, 64'h01_01, 2);
    join
    idle(10);

    // Single packet from src0
    exp_pkt(3'b001, 64'h0E_A3_A2_A1_0D, 5);
    send(0, 64'h0E_A3_A2_A1_0D, 5);
    idle(10);

    // Busy stall after the second payload byte (src1)
    exp_pkt(3'b010, 64'h0E_A3_A2_A1_0D, 5);
    fork
      send(1, 64'h0E_A3_A2_A1_0D, 5);
      begin : stall
        int t;
        t = 0;
        do begin
          @(negedge clock);
          t++;
        end while (!(src_valid[1] && src_ready[1] && src_data[15:8] == 8'hA2) && t < 300);
        check("stall_arm_in_time", t < 300, 1);
        @(posedge clock);
        #1 busy = 1'b1;
        repeat (4) begin
          @(negedge clock);
          check("stall_src_ready", src_ready, 0);
          check("stall_data_in", data_in, 8'hA2);
          check("stall_pkt_valid", pkt_valid, 1);
        end
        @(posedge clock);
        #1 busy = 1'b0;
      end
    join
    idle(10);

    // Drop (src2, addr 3) racing a zero-length packet from src0
    sb.push_back(xr(1'b0, 8'h0E, 3'b100, 1'b0));
    sb.push_back(xr(1'b0, 8'h0E, 3'b100, 1'b0));
    sb.push_back(xr(1'b0, 8'h0E, 3'b000, 1'b1));
    sb.push_back(rl(1));
    exp_pkt(3'b001, 64'h00_00, 2);
    fork
      send(2, 64'h3C_5A_07, 3);
      send(0, 64'h00_00, 2);
    join
    idle(10);

    // Underrun on src1
    underrun_pkt(1, 3'b010);

    // Reset while src1's second payload byte is presented
    sb.push_back(xr(1'b1, 8'h0D, 3'b010, 1'b0));
    sb.push_back(xr(1'b1, 8'hA1, 3'b010, 1'b0));
    hold_byte(1, 8'h0D);
    hold_byte(1, 8'hA1);
    src_data[15:8] = 8'hA2;
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("arst_pkt_valid", pkt_valid, 0);
    check("arst_data_in", data_in, 0);
    check("arst_grant", grant, 0);
    check("arst_src_ready", src_ready, 0);
    check("arst_underrun", underrun_err, 0);
    src_valid[1] = 1'b0;
    @(negedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // Fresh arbitration from src0 after reset
    exp_pkt(3'b001, 64'h14_11_05, 3);
    exp_pkt(3'b100, 64'h37_33_04, 3);
    fork
      send(0, 64'h14_11_05, 3);
      send(2, 64'h37_33_04, 3);
    join
    idle(10);

    // Underrun after reset
    underrun_pkt(1, 3'b010);

    idle(5);
    check("scoreboard_drained", sb.size(), 0);
    check("drop_pulse_cycles", drop_seen, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
